vector_main_memory: RTL and testbench

VECTOR_MAIN_MEMORY -- requirements
Module: vector_main_memory

---
 rtl/vector_main_memory.sv | 112 +++++++++++
 tb/tb_vector_main_memory.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_main_memory.sv
// Vector main memory: DEPTH x W-bit words, zero-cleared after reset,
// latency-1 reads with write-first forwarding and a lower-priority host preload port.
module vector_main_memory #(
    parameter int DEPTH = 256,
    parameter int W     = 512
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          load_ctrl,
    input  logic [15:0]   load_addr,
    output logic [W-1:0]  load_data,
    output logic          load_valid,
    input  logic          write_ctrl,
    input  logic [15:0]   write_addr,
    input  logic [W-1:0]  write_data,
    input  logic          host_we,
    input  logic [15:0]   host_addr,
    input  logic [W-1:0]  host_data,
    output logic          host_ack,
    output logic          busy,
    output logic          addr_err
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {CLEAR, READY} state_t;

    state_t         state;
    logic [AW-1:0]  cnt;
    logic [W-1:0]   mem [DEPTH];

    logic           ready;
    logic           r_ok;
    logic           w_ok;
    logic           h_ok;
    logic           wen;
    logic           fwd;
    logic [AW-1:0]  waddr;
    logic [W-1:0]   wdata;

    assign ready    = (state == READY) && !reset;
    assign r_ok     = {1'b0, load_addr} < 17'(DEPTH);
    assign w_ok     = {1'b0, write_addr} < 17'(DEPTH);
    assign h_ok     = {1'b0, host_addr} < 17'(DEPTH);
    assign host_ack = ready && host_we && !write_ctrl;

    // One shared write port: sweep, then processing block, then host.
    always_comb begin
        wen   = 1'b0;
        waddr = cnt;
        wdata = '0;
        if (!reset) begin
            if (state == CLEAR) begin
                wen = 1'b1;
            end else if (write_ctrl) begin
                wen   = w_ok;
                waddr = write_addr[AW-1:0];
                wdata = write_data;
            end else if (host_ack) begin
                wen   = h_ok;
                waddr = host_addr[AW-1:0];
                wdata = host_data;
            end
        end
    end

    assign fwd = ready && wen && (waddr == load_addr[AW-1:0]);

    always_ff @(posedge clock) begin
        if (wen) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= CLEAR;
            cnt        <= '0;
            busy       <= 1'b1;
            load_data  <= '0;
            load_valid <= 1'b0;
            addr_err   <= 1'b0;
        end else begin
            load_valid <= 1'b0;
            unique case (state)
                CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == AW'(DEPTH - 1)) begin
                        state <= READY;
                        busy  <= 1'b0;
                    end
                end
                READY: begin
                    if (load_ctrl) begin
                        load_valid <= 1'b1;
                        if (!r_ok) begin
                            load_data <= '0;
                            addr_err  <= 1'b1;
                        end else if (fwd) begin
                            load_data <= wdata;
                        end else begin
                            load_data <= mem[load_addr[AW-1:0]];
                        end
                    end
                    if ((write_ctrl && !w_ok) || (host_ack && !h_ok)) begin
                        addr_err <= 1'b1;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end
endmodule

// File: tb/tb_vector_main_memory.sv
// Scoreboard bench for vector_main_memory: expected read data is queued
// when a load is issued and checked when load_valid appears.
module tb_vector_main_memory;
    localparam int DEPTH = 256;
    localparam int W     = 512;

    logic          clock = 1'b0;
    logic          reset;
    logic          load_ctrl;
    logic [15:0]   load_addr;
    logic [W-1:0]  load_data;
    logic          load_valid;
    logic          write_ctrl;
    logic [15:0]   write_addr;
    logic [W-1:0]  write_data;
    logic          host_we;
    logic [15:0]   host_addr;
    logic [W-1:0]  host_data;
    logic          host_ack;
    logic          busy;
    logic          addr_err;

    int compared = 0;
    int mismatched = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] model [DEPTH];

    vector_main_memory #(.DEPTH(DEPTH), .W(W)) dut (
        .clock(clock), .reset(reset),
        .load_ctrl(load_ctrl), .load_addr(load_addr),
        .load_data(load_data), .load_valid(load_valid),
        .write_ctrl(write_ctrl), .write_addr(write_addr),
        .write_data(write_data),
        .host_we(host_we), .host_addr(host_addr),
        .host_data(host_data), .host_ack(host_ack),
        .busy(busy), .addr_err(addr_err)
    );

    always #5 clock = ~clock;

    function automatic logic [W-1:0] rep16(input logic [15:0] v);
        return {32{v}};
    endfunction

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] r;
        for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic idle();
        load_ctrl = 0; load_addr = 0;
        write_ctrl = 0; write_addr = 0; write_data = '0;
        host_we = 0; host_addr = 0; host_data = '0;
    endtask

    // Advance one edge, sample 1 ns later and pop the scoreboard on load_valid.
    task automatic step();
        logic [W-1:0] e;
        @(posedge clock);
        #1;
        if (load_valid) begin
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_load: load_valid=1 data=%h, required no read", load_data[63:0]);
            end else begin
                e = exp_q.pop_front();
                if (load_data !== e) begin
                    mismatched++;
                    $display("FAIL load_data: got %h required %h (low 64b)", load_data[63:0], e[63:0]);
                end
            end
        end
    endtask

    task automatic check_drained(input string name);
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL %s: %0d reads outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic read(input logic [15:0] a);
        load_ctrl = 1; load_addr = a;
        exp_q.push_back(a < DEPTH ? model[a] : '0);
    endtask

    task automatic wait_ready(input int required);
        int n = 0;
        while (busy && n < 1000) begin
            step();
            n++;
        end
        compared++;
        if (n != required) begin
            mismatched++;
            $display("FAIL clear_cycles: got %0d required %0d", n, required);
        end
    endtask

    task automatic test_reset();
        idle();
        reset = 1; host_we = 1;
        step();
        compared++;
        if (busy !== 1 || load_valid !== 0 || load_data !== '0 ||
            addr_err !== 0 || host_ack !== 0) begin
            mismatched++;
            $display("FAIL reset_state: busy=%b valid=%b data0=%b err=%b ack=%b, required 1 0 1 0 0",
                     busy, load_valid, load_data == '0, addr_err, host_ack);
        end
        reset = 0;
        // Requests held through the sweep must all be ignored.
        load_ctrl = 1; load_addr = 7;
        write_ctrl = 1; write_addr = 7; write_data = rep16(16'hdead);
        host_addr = 8; host_data = rep16(16'hbeef);
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        begin
            int n = 0;
            int acks = 0;
            while (busy && n < 1000) begin
                if (host_ack !== 0) acks++;
                step();
                n++;
            end
            compared++;
            if (n != DEPTH) begin
                mismatched++;
                $display("FAIL clear_cycles: got %0d required %0d", n, DEPTH);
            end
            compared++;
            if (acks != 0) begin
                mismatched++;
                $display("FAIL clear_host_ack: got %0d acks required 0", acks);
            end
        end
        idle();
        read(0); step();
        read(7); step();
        read(8); step();
        read(DEPTH - 1); step();
        idle(); step();
        check_drained("reset_reads");
    endtask

    task automatic test_host_load();
        host_we = 1; host_addr = 0; host_data = rep16(16'h3e4d);
        #1;
        compared++;
        if (host_ack !== 1) begin
            mismatched++;
            $display("FAIL host_ack0: got %b required 1", host_ack);
        end
        model[0] = host_data;
        step();
        host_addr = 1; host_data = rep16(16'h4000);
        model[1] = host_data;
        step();
        idle();
        read(0); step();
        read(1); step();
        idle(); step();
        check_drained("host_load");
        compared++;
        if (load_valid !== 0 || load_data !== rep16(16'h4000)) begin
            mismatched++;
            $display("FAIL hold_data: valid=%b data=%h, required 0 and 4000 lanes",
                     load_valid, load_data[63:0]);
        end
    endtask

    task automatic test_forward();
        write_ctrl = 1; write_addr = 3; write_data = rep16(16'h3f1a);
        model[3] = write_data;
        read(3);
        step();
        idle();
        host_we = 1; host_addr = 9; host_data = rep16(16'h1234);
        model[9] = host_data;
        read(9);
        step();
        idle();
        read(3); step();
        read(9); step();
        idle(); step();
        check_drained("forward");
    endtask

    task automatic test_priority();
        host_we = 1; host_addr = 5; host_data = rep16(16'h5555);
        write_ctrl = 1; write_addr = 6; write_data = rep16(16'h6666);
        #1;
        compared++;
        if (host_ack !== 0) begin
            mismatched++;
            $display("FAIL prio_ack_blocked: got %b required 0", host_ack);
        end
        model[6] = write_data;
        step();
        write_ctrl = 0;
        #1;
        compared++;
        if (host_ack !== 1) begin
            mismatched++;
            $display("FAIL prio_ack_later: got %b required 1", host_ack);
        end
        model[5] = host_data;
        step();
        idle();
        read(5); step();
        read(6); step();
        idle(); step();
        check_drained("priority");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            write_ctrl = 1; write_addr = 16'(16 + i); write_data = rand_word();
            model[16 + i] = write_data;
            step();
        end
        idle();
        for (int i = 0; i < 8; i++) begin
            read(16'(23 - i));
            step();
        end
        idle(); step();
        check_drained("back_to_back");
    endtask

    task automatic test_addr_err();
        compared++;
        if (addr_err !== 0) begin
            mismatched++;
            $display("FAIL err_before: got %b required 0", addr_err);
        end
        read(300);
        step();
        idle();
        compared++;
        if (addr_err !== 1) begin
            mismatched++;
            $display("FAIL err_set: got %b required 1", addr_err);
        end
        write_ctrl = 1; write_addr = DEPTH + 3; write_data = rep16(16'hffff);
        step();
        idle();
        read(3); step();
        read(DEPTH); step();
        idle();
        for (int i = 0; i < 5; i++) step();
        check_drained("addr_err");
        compared++;
        if (addr_err !== 1) begin
            mismatched++;
            $display("FAIL err_sticky: got %b required 1", addr_err);
        end
    endtask

    task automatic test_reset_ready();
        load_ctrl = 1; load_addr = 0;
        reset = 1;
        step();
        compared++;
        if (load_valid !== 0 || addr_err !== 0 || busy !== 1) begin
            mismatched++;
            $display("FAIL reset_ready: valid=%b err=%b busy=%b required 0 0 1",
                     load_valid, addr_err, busy);
        end
        reset = 0;
        idle();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        wait_ready(DEPTH);
        read(0); step();
        read(3); step();
        read(16); step();
        idle(); step();
        check_drained("reset_ready");
    endtask

    task automatic test_reset_mid_clear();
        reset = 1;
        step();
        reset = 0;
        for (int i = 0; i < 100; i++) step();
        compared++;
        if (busy !== 1) begin
            mismatched++;
            $display("FAIL mid_clear_busy: got %b required 1", busy);
        end
        reset = 1;
        step();
        reset = 0;
        wait_ready(DEPTH);
    endtask

    initial begin
        idle();
        reset = 1;
        test_reset();
        test_host_load();
        test_forward();
        test_priority();
        test_back_to_back();
        test_addr_err();
        test_reset_ready();
        test_reset_mid_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
